// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register with one-entry skid buffer and flush.
// Main entry drives MEM and the forwarding port; skid absorbs one stall.
module ex_mem_pipe #(
  parameter int XLEN          = 32,
  parameter int REG_AW        = 5,
  parameter int LOAD_W        = 5,
  parameter int STORE_W       = 3,
  parameter int NO_LOAD_CODE  = 0,
  parameter int NO_STORE_CODE = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               valid_in,
  output logic               ready_out,
  input  logic [XLEN-1:0]    rd_in,
  input  logic               rd_en_in,
  input  logic [REG_AW-1:0]  rd_addr_in,
  input  logic [LOAD_W-1:0]  load_flag_in,
  input  logic [STORE_W-1:0] store_flag_in,
  input  logic [XLEN-1:0]    store_data_in,
  output logic               valid_out,
  input  logic               ready_in,
  output logic [XLEN-1:0]    rd_out,
  output logic               rd_en_out,
  output logic [REG_AW-1:0]  rd_addr_out,
  output logic [LOAD_W-1:0]  load_flag_out,
  output logic [STORE_W-1:0] store_flag_out,
  output logic [XLEN-1:0]    store_data_out,
  output logic               fwd_valid,
  output logic [REG_AW-1:0]  fwd_addr,
  output logic [XLEN-1:0]    fwd_data,
  output logic               fwd_is_load
);

  typedef struct packed {
    logic [XLEN-1:0]    rd;
    logic               rd_en;
    logic [REG_AW-1:0]  rd_addr;
    logic [LOAD_W-1:0]  load;
    logic [STORE_W-1:0] store;
    logic [XLEN-1:0]    sdata;
  } bundle_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  localparam logic [LOAD_W-1:0]  NO_LOAD  = LOAD_W'(NO_LOAD_CODE);
  localparam logic [STORE_W-1:0] NO_STORE = STORE_W'(NO_STORE_CODE);

  state_t  state;
  bundle_t main_q;
  bundle_t skid_q;
  bundle_t in_b;
  bundle_t neutral;
  logic    valid_q;
  logic    ready_q;
  logic    accept;
  logic    drain;

  always_comb begin
    neutral         = '0;
    neutral.load    = NO_LOAD;
    neutral.store   = NO_STORE;
    in_b.rd         = rd_in;
    // x0 is hardwired zero, so a write to it must never forward
    in_b.rd_en      = rd_en_in & (rd_addr_in != '0);
    in_b.rd_addr    = rd_addr_in;
    in_b.load       = load_flag_in;
    in_b.store      = store_flag_in;
    in_b.sdata      = store_data_in;
  end

  assign accept = valid_in & ready_q;
  assign drain  = valid_q & ready_in;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state   <= EMPTY;
      main_q  <= neutral;
      skid_q  <= neutral;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            main_q  <= in_b;
            valid_q <= 1'b1;
            state   <= ONE;
          end
        end
        ONE: begin
          if (drain && accept) begin
            main_q <= in_b;
          end else if (drain) begin
            main_q  <= neutral;
            valid_q <= 1'b0;
            state   <= EMPTY;
          end else if (accept) begin
            skid_q  <= in_b;
            ready_q <= 1'b0;
            state   <= FULL;
          end
        end
        FULL: begin
          if (drain) begin
            main_q  <= skid_q;
            skid_q  <= neutral;
            ready_q <= 1'b1;
            state   <= ONE;
          end
        end
        default: begin
          state   <= EMPTY;
          main_q  <= neutral;
          skid_q  <= neutral;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready_out      = ready_q;
  assign valid_out      = valid_q;
  assign rd_out         = main_q.rd;
  assign rd_en_out      = main_q.rd_en;
  assign rd_addr_out    = main_q.rd_addr;
  assign load_flag_out  = main_q.load;
  assign store_flag_out = main_q.store;
  assign store_data_out = main_q.sdata;

  assign fwd_valid   = main_q.rd_en & valid_q;
  assign fwd_addr    = main_q.rd_addr;
  assign fwd_data    = main_q.rd;
  assign fwd_is_load = valid_q & (main_q.load != NO_LOAD);

endmodule

// File: doc/ex_mem_pipe.md
Name: ex_mem_pipe

Overview:
Parametrised EX→MEM pipeline register for the CPU core. It carries the execute-stage result bundle (rd value/enable/address, load/store flags, store data) to the memory stage. It adds a valid/ready handshake, a one-entry skid buffer so upstream ready is registered, and pipeline flush. It also drives a forwarding/hazard port for the decode/execute bypass logic.

Parameters:
XLEN, 32, data width of rd and store data
REG_AW, 5, register address width
LOAD_W, 5, load flag width
STORE_W, 3, store flag width
NO_LOAD_CODE, 0, load flag value meaning "no load"
NO_STORE_CODE, 0, store flag value meaning "no store"

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  kill all held entries and the current input
valid_in  in  1  EX presents a bundle
ready_out  out  1  module can accept (registered)
rd_in  in  XLEN  result value
rd_en_in  in  1  register write enable
rd_addr_in  in  REG_AW  destination register
load_flag_in  in  LOAD_W  load type
store_flag_in  in  STORE_W  store type
store_data_in  in  XLEN  store data
valid_out  out  1  bundle presented to MEM
ready_in  in  1  MEM accepts
rd_out, rd_en_out, rd_addr_out, load_flag_out, store_flag_out, store_data_out  out  (as inputs)  registered bundle
fwd_valid  out  1  rd_en_out & valid_out
fwd_addr  out  REG_AW  = rd_addr_out
fwd_data  out  XLEN  = rd_out
fwd_is_load  out  1  valid_out & (load_flag_out != NO_LOAD_CODE), load-use hazard flag

Behaviour:
- Single clock; all state updates on posedge clk. Reset is sampled only at the edge.
- Accept = valid_in & ready_out. Drain = valid_out & ready_in.
- Storage: main entry (drives outputs) and skid entry. States: EMPTY, ONE (main valid), FULL (main+skid valid).
- ready_out = !skid_valid, taken directly from a register. valid_out = main_valid.
- Transitions (no flush):
  EMPTY: accept → ONE, main<=in; else stay.
  ONE: drain & accept → ONE, main<=in; drain & !accept → EMPTY; !drain & accept → FULL, skid<=in; else hold.
  FULL: drain → ONE, main<=skid; else hold (no accept possible).
- Latency: 1 cycle from accept to valid_out. Full throughput (1/cycle) while ready_in=1.
- Outputs hold stable while valid_out & !ready_in.
- Sanitising on capture:
  - rd_en forced 0 when rd_addr_in == 0 (x0 write suppressed).
  - When an entry becomes invalid (EMPTY), main payload is loaded with the neutral bundle: rd=0, rd_en=0, rd_addr=0, load=NO_LOAD_CODE, store=NO_STORE_CODE, store_data=0.
  - MEM may therefore rely on the flags even when valid_out=0.
- flush: next cycle state EMPTY, main and skid invalid, main payload neutral, ready_out=1. Any input presented in the flush cycle is dropped.
- Priority: rst > flush > handshake.
- Reset: state EMPTY, valid_out=0, ready_out=1, all payload outputs neutral, fwd_* = 0.
- Reset or flush mid-FULL discards both entries; no partial drain.
- Forwarding outputs are combinational from the main register only. The skid entry is not forwarded; the hazard unit stalls EX while ready_out=0.

Test Plan:
- Reset: assert rst 2 cycles with valid_in=1 → valid_out=0, ready_out=1, rd_en_out=0, load_flag_out=NO_LOAD_CODE, store_flag_out=NO_STORE_CODE.
- Streaming: ready_in=1, send rd=0x11,0x22,0x33 (rd_addr=5, rd_en=1) on consecutive cycles → rd_out matches each one cycle later, with no bubbles.
- Backpressure: ready_in=0, send A=0xA then B=0xB → FULL and ready_out=0, rd_out=0xA held. Raise ready_in → 0xA drains, then 0xB, ready_out returns to 1. No loss or duplication.
- Flush: in FULL state assert flush with valid_in=1, rd=0xC → next cycle valid_out=0, ready_out=1, store_flag_out=NO_STORE_CODE, 0xC never appears.
- x0 suppression: rd_addr_in=0, rd_en_in=1, rd=0xFF → rd_en_out=0, fwd_valid=0.
- Load hazard: load_flag_in=non-zero, rd_addr=7 → fwd_is_load=1, fwd_addr=7 while valid_out=1. Drops to 0 after drain with no new input.
